// File: rtl/game_pkg.sv
// Shared types and move codes for the tile game: controller, engine and VGA renderer.
package game_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ISSUE   = 2'd1,
      BUSY    = 2'd2,
      RELEASE = 2'd3
   } mc_state_t;

   localparam logic [2:0] MOVE_NONE  = 3'd0;
   localparam logic [2:0] MOVE_LEFT  = 3'd1;
   localparam logic [2:0] MOVE_RIGHT = 3'd2;
   localparam logic [2:0] MOVE_UP    = 3'd3;
   localparam logic [2:0] MOVE_DOWN  = 3'd4;

endpackage

// File: rtl/btn_debounce.sv
// One push-button front end: 2-flop synchroniser, stable-count debouncer and a
// one-cycle press pulse on each debounced 1->0 transition.
module btn_debounce #(
   parameter int DEBOUNCE = 500000
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_n,
   output logic level,
   output logic press
);

   localparam int DW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;

   logic          sync1;
   logic          sync2;
   logic [1:0]    fill;
   logic          armed;
   logic [DW-1:0] cnt;

   // A button held through reset debounces low without a press: the pulse is
   // only armed once a genuine released sample has passed the synchroniser.
   always_ff @(posedge clk) begin
      if (!rst) begin
         sync1 <= 1'b1;
         sync2 <= 1'b1;
         fill  <= 2'b00;
         armed <= 1'b0;
         level <= 1'b1;
         press <= 1'b0;
         cnt   <= '0;
      end else begin
         sync1 <= btn_n;
         sync2 <= sync1;
         fill  <= {fill[0], 1'b1};
         press <= 1'b0;
         if (fill[1] && sync2)
            armed <= 1'b1;
         if (sync2 == level) begin
            cnt <= '0;
         end else if (cnt == DW'(DEBOUNCE - 1)) begin
            cnt   <= '0;
            level <= sync2;
            press <= ~sync2 & armed;
         end else begin
            cnt <= cnt + DW'(1);
         end
      end
   end

endmodule

// File: rtl/move_ctrl.sv
// Player-input controller: debounced, prioritised move commands handed to the
// game engine over valid/ready, locked out until the board update completes.
//
// state   | meaning
// IDLE    | waiting for a fresh debounced press
// ISSUE   | offering move_dir with move_valid until move_ready
// BUSY    | command accepted, engine applying it; presses ignored
// RELEASE | waiting for all buttons up, or repeat timer on a held button
module move_ctrl
   import game_pkg::*;
#(
   parameter int N_BTN    = 4,
   parameter int CW       = $clog2(N_BTN + 1),
   parameter int DEBOUNCE = 500000,
   parameter int REPEAT   = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N_BTN-1:0] btn_n,
   output logic             move_valid,
   output logic [CW-1:0]    move_dir,
   input  logic             move_ready,
   input  logic             upd_done,
   output logic             busy
);

   localparam int RW    = (REPEAT > 1) ? $clog2(REPEAT) : 1;
   localparam int RLOAD = (REPEAT > 0) ? REPEAT - 1 : 0;

   logic [N_BTN-1:0] level;
   logic [N_BTN-1:0] press;

   for (genvar i = 0; i < N_BTN; i++) begin : g_btn
      btn_debounce #(
         .DEBOUNCE(DEBOUNCE)
      ) u_db (
         .clk   (clk),
         .rst   (rst),
         .btn_n (btn_n[i]),
         .level (level[i]),
         .press (press[i])
      );
   end

   mc_state_t     state, state_n;
   logic [CW-1:0] code, code_n;
   logic [RW-1:0] rcnt, rcnt_n;
   logic [CW-1:0] pick;
   logic          held;
   logic          valid_n;
   logic          busy_n;
   logic [CW-1:0] dir_n;

   // Lowest index wins; scanning downwards lets the lowest set bit overwrite.
   always_comb begin
      pick = '0;
      for (int i = N_BTN - 1; i >= 0; i--) begin
         if (press[i])
            pick = CW'(i + 1);
      end
   end

   always_comb begin
      held = 1'b0;
      for (int i = 0; i < N_BTN; i++) begin
         if (code == CW'(i + 1) && !level[i])
            held = 1'b1;
      end
   end

   always_comb begin
      state_n = state;
      code_n  = code;
      rcnt_n  = rcnt;
      case (state)
         IDLE: begin
            if (pick != '0) begin
               code_n  = pick;
               state_n = ISSUE;
            end
         end
         ISSUE: begin
            if (move_ready)
               state_n = BUSY;
         end
         BUSY: begin
            if (upd_done) begin
               state_n = RELEASE;
               rcnt_n  = RW'(RLOAD);
            end
         end
         RELEASE: begin
            if (&level) begin
               state_n = IDLE;
            end else if (REPEAT > 0 && held) begin
               if (rcnt == '0)
                  state_n = ISSUE;
               else
                  rcnt_n = rcnt - RW'(1);
            end
         end
         default: state_n = IDLE;
      endcase
      // Outputs are decoded from the next state so they leave a flop directly.
      valid_n = (state_n == ISSUE);
      busy_n  = (state_n == BUSY);
      dir_n   = valid_n ? code_n : '0;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state      <= IDLE;
         code       <= '0;
         rcnt       <= '0;
         move_valid <= 1'b0;
         move_dir   <= '0;
         busy       <= 1'b0;
      end else begin
         state      <= state_n;
         code       <= code_n;
         rcnt       <= rcnt_n;
         move_valid <= valid_n;
         move_dir   <= dir_n;
         busy       <= busy_n;
      end
   end

endmodule
